mem_rdq: RTL and testbench

Single-clock parametrised RAM with byte-enable writes and a flow-controlled, registered read port backed by a 2-entry output queue. It succeeds the plain dual-clock FIFO storage array: it supplies storage for single-clock buffers and table lookups where the consumer can stall. Read data is returned in request order with a valid/ack handshake, and no read result is ever dropped.

---
 rtl/mem_rdq_pkg.sv | 18 +
 rtl/mem_rdq_buf.sv | 30 +++
 rtl/mem_rdq.sv | 49 ++++
 tb/tb_mem_rdq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_rdq_pkg.sv
// mem_pkg: shared types and helpers for the mem_rdq RAM with queued read port
package mem_pkg;
    localparam int MAX_W = 1024;
    localparam int MAX_B = MAX_W / 8;
    typedef logic [1:0] cnt_t;
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
    // Words are zero-extended to MAX_W by callers and truncated on return
    function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0] old_w,
                                               input logic [MAX_W-1:0] new_w,
                                               input logic [MAX_B-1:0] be);
        logic [MAX_W-1:0] m;
        for (int i = 0; i < MAX_B; i++)
            m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return m;
    endfunction
endpackage

// File: rtl/mem_rdq_buf.sv
// mem_rdq_buf: 2-entry in-order output queue for read results
module mem_rdq_buf import mem_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] data,
    output cnt_t             cnt,
    output logic             r_valid,
    output logic             r_rdy
);
    logic [WIDTH-1:0] q1;
    assign r_valid = cnt != 2'd0;
    assign r_rdy   = cnt != 2'd2;
    // push never coincides with cnt==2, so a pop with push always lands the new word at the head
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            cnt  <= '0;
            data <= '0;
            q1   <= '0;
        end else begin
            cnt <= cnt + cnt_t'(push) - cnt_t'(pop);
            if (pop) data <= push ? d : q1;
            else if (push && cnt == 2'd0) data <= d;
            if (push && !pop && cnt != 2'd0) q1 <= d;
        end
endmodule

// File: rtl/mem_rdq.sv
// mem_rdq: byte-enable RAM with registered, flow-controlled read queue.
// Define MEM_RDQ_FWD_EN to forward same-cycle writes into colliding reads.
module mem_rdq import mem_pkg::*; #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int AW    = addr_w(DEPTH),
    localparam int BW    = WIDTH / 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             w_en,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic [BW-1:0]    w_be,
    input  logic             r_req,
    input  logic [AW-1:0]    r_addr,
    output logic             r_rdy,
    output logic             r_valid,
    output logic [WIDTH-1:0] r_data,
    input  logic             r_ack
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] wr_word, rd_word;
    cnt_t cnt;
    logic push, pop;
    assign wr_word = WIDTH'(merge(MAX_W'(mem[w_addr]), MAX_W'(w_data), MAX_B'(w_be)));
`ifdef MEM_RDQ_FWD_EN
    assign rd_word = (w_en && w_addr == r_addr)
        ? WIDTH'(merge(MAX_W'(mem[r_addr]), MAX_W'(w_data), MAX_B'(w_be)))
        : mem[r_addr];
`else
    assign rd_word = mem[r_addr];
`endif
    assign push = r_req & r_rdy;
    assign pop  = r_ack & (cnt != 2'd0);
    always_ff @(posedge clock)
        if (w_en) mem[w_addr] <= wr_word;
    mem_rdq_buf #(.WIDTH(WIDTH)) u_buf (
        .clock   (clock),
        .resetn  (resetn),
        .push    (push),
        .pop     (pop),
        .d       (rd_word),
        .data    (r_data),
        .cnt     (cnt),
        .r_valid (r_valid),
        .r_rdy   (r_rdy)
    );
endmodule

// File: tb/tb_mem_rdq.sv
// tb_mem_rdq: directed self-checking bench for mem_rdq (DEPTH=16, WIDTH=32)
module tb_mem_rdq;
    logic        clock = 0;
    logic        resetn = 0;
    logic        w_en = 0;
    logic [3:0]  w_addr = 0;
    logic [31:0] w_data = 0;
    logic [3:0]  w_be = 0;
    logic        r_req = 0;
    logic [3:0]  r_addr = 0;
    logic        r_rdy, r_valid, r_ack = 0;
    logic [31:0] r_data;
    int n_tests = 0;
    int n_fail = 0;

    mem_rdq #(.DEPTH(16), .WIDTH(32)) dut (
        .clock(clock), .resetn(resetn), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .w_be(w_be), .r_req(r_req), .r_addr(r_addr), .r_rdy(r_rdy), .r_valid(r_valid),
        .r_data(r_data), .r_ack(r_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        w_en = 1; w_addr = a; w_data = d; w_be = be;
        tick();
        w_en = 0;
    endtask

    task automatic read_one(input string tag, input logic [3:0] a, input logic [31:0] exp);
        r_req = 1; r_addr = a; r_ack = 0;
        tick();
        r_req = 0;
        check({tag, "_valid"}, 32'(r_valid), 32'd1);
        check({tag, "_data"}, r_data, exp);
        r_ack = 1;
        tick();
        r_ack = 0;
        check({tag, "_empty"}, 32'(r_valid), 32'd0);
    endtask

    initial begin
        tick();
        check("rst_rdy", 32'(r_rdy), 32'd1);
        check("rst_valid", 32'(r_valid), 32'd0);
        check("rst_data", r_data, 32'd0);
        resetn = 1;
        tick();

        write(4'd3, 32'hDEADBEEF, 4'hF);
        r_req = 1; r_addr = 4'd3;
        check("t1_pre_valid", 32'(r_valid), 32'd0);
        r_req = 0;
        read_one("t1", 4'd3, 32'hDEADBEEF);
        write(4'd3, 32'h0, 4'h0);
        read_one("be0_noop", 4'd3, 32'hDEADBEEF);

        write(4'd5, 32'h11223344, 4'hF);
        write(4'd5, 32'hAABBCCDD, 4'b0101);
        read_one("t2", 4'd5, 32'h11BB33DD);

        write(4'd0, 32'hA0A0A0A0, 4'hF);
        write(4'd1, 32'hA1A1A1A1, 4'hF);
        write(4'd2, 32'hA2A2A2A2, 4'hF);
        r_ack = 0; r_req = 1; r_addr = 4'd0;
        tick();
        check("t3_rdy_after1", 32'(r_rdy), 32'd1);
        r_addr = 4'd1;
        tick();
        check("t3_full_rdy", 32'(r_rdy), 32'd0);
        check("t3_full_head", r_data, 32'hA0A0A0A0);
        r_addr = 4'd2;
        tick();
        check("t3_stall_rdy", 32'(r_rdy), 32'd0);
        check("t3_stall_head", r_data, 32'hA0A0A0A0);
        r_ack = 1;
        tick();
        check("t3_pop_rdy", 32'(r_rdy), 32'd1);
        check("t3_pop_head", r_data, 32'hA1A1A1A1);
        r_ack = 0;
        tick();
        r_req = 0;
        check("t3_acc2_rdy", 32'(r_rdy), 32'd0);
        check("t3_acc2_head", r_data, 32'hA1A1A1A1);
        r_ack = 1;
        tick();
        check("t3_last_head", r_data, 32'hA2A2A2A2);
        tick();
        check("t3_drained", 32'(r_valid), 32'd0);
        tick();
        check("ack_empty_ignored", 32'(r_rdy), 32'd1);
        r_ack = 0;

        write(4'd7, 32'h000000AA, 4'hF);
        w_en = 1; w_addr = 4'd7; w_data = 32'h12345678; w_be = 4'b0001;
        r_req = 1; r_addr = 4'd7;
        tick();
        w_en = 0; r_req = 0;
`ifdef MEM_RDQ_FWD_EN
        check("t4_collide", r_data, 32'h00000078);
`else
        check("t4_collide", r_data, 32'h000000AA);
`endif
        r_ack = 1;
        tick();
        r_ack = 0;
        read_one("t4_after", 4'd7, 32'h00000078);

        write(4'd15, 32'hF00DF00D, 4'hF);
        r_ack = 1; r_req = 1;
        for (int i = 0; i < 6; i++) begin
            r_addr = (i % 2 == 0) ? 4'd15 : 4'd0;
            tick();
            check($sformatf("t5_valid%0d", i), 32'(r_valid), 32'd1);
            check($sformatf("t5_rdy%0d", i), 32'(r_rdy), 32'd1);
            check($sformatf("t5_data%0d", i), r_data, (i % 2 == 0) ? 32'hF00DF00D : 32'hA0A0A0A0);
        end
        r_req = 0;
        tick();
        r_ack = 0;
        check("t5_drained", 32'(r_valid), 32'd0);

        r_req = 1; r_addr = 4'd3;
        tick();
        r_addr = 4'd5;
        tick();
        r_req = 0;
        check("t6_full", 32'(r_rdy), 32'd0);
        resetn = 0;
        #1;
        check("t6_rst_valid", 32'(r_valid), 32'd0);
        check("t6_rst_rdy", 32'(r_rdy), 32'd1);
        check("t6_rst_data", r_data, 32'd0);
        tick();
        resetn = 1;
        tick();
        check("t6_post_valid", 32'(r_valid), 32'd0);
        check("t6_post_data", r_data, 32'd0);
        read_one("t6_reread", 4'd3, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
